hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. It drives Stall/Flush to the F/D, D/E and E/M

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_ctrl_forward_unit.sv | 22 ++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [4:0]  REG_X0    = 5'd0;

    // x0 is hardwired to zero, so it never produces a real dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// E-stage operand forwarding select: M-stage result wins over W-stage result.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_NONE;
        if (reg_write_m_i && reg_match(rd_m_i, rs_e_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (reg_write_w_i && reg_match(rd_w_i, rs_e_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding sequencer for the 5-stage core.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic [4:0]        RdM,
    input  logic [4:0]        RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemErr,
    output logic [PERF_W-1:0] StallCnt,
    output logic [PERF_W-1:0] FlushCnt,
    output logic              DbgState
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             flush_pend_q;
    logic             mem_hold;
    logic             load_use;
    logic [1:0]       fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_sel_o     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_sel_o     (fwd_b)
    );

    // E holds reset garbage while the post-reset flush is pending; never forward into it.
    assign ForwardAE = flush_pend_q ? FWD_NONE : fwd_a;
    assign ForwardBE = flush_pend_q ? FWD_NONE : fwd_b;
    assign DbgState  = (state_q == MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_hold   = 1'b0;
        MemErr     = 1'b0;
        case (state_q)
            RUN: begin
                if (!flush_pend_q && MemReqM && !MemReadyM) begin
                    mem_hold   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_MAX) begin
                    // Abandon the access: release the pipe and report once.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    MemErr     = 1'b1;
                end else begin
                    mem_hold   = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign load_use = ResultSrcE0 && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (flush_pend_q) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (FlushE) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;

    localparam int PERF_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd8;
    localparam logic [31:0] EXP_FLUSH = 32'd4;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic              StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr, DbgState;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [PERF_W-1:0] StallCnt, FlushCnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
        .DbgState(DbgState)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stall/flush vector packed as {StallF,StallD,StallE,StallM,FlushD,FlushE}.
    function automatic logic [31:0] sf();
        return {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        MemReqM = 1'b1;
        #12;
        check("reset_stall_flush", sf(), 32'b000011);
        check("reset_fwd", {ForwardAE, ForwardBE}, 32'd0);
        check("reset_memerr", MemErr, 32'd0);
        check("reset_stallcnt", StallCnt, 32'd0);
        MemReqM = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("release_cycle_flush", sf(), 32'b000011);
        cyc(); smp();
        check("post_release_flush", sf(), 32'b000000);
        check("post_release_fwd", {ForwardAE, ForwardBE}, 32'd0);
        check("post_release_state", DbgState, 32'd0);

        // Forwarding
        cyc();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        smp();
        check("fwd_a_mem_prio", ForwardAE, 32'b10);
        check("fwd_b_mem_prio", ForwardBE, 32'b10);
        cyc(); RdM = 0;
        smp();
        check("fwd_a_wb_rdm0", ForwardAE, 32'b01);
        cyc(); RdM = 5; RegWriteM = 0; Rs2E = 9;
        smp();
        check("fwd_a_wb_nowrm", ForwardAE, 32'b01);
        check("fwd_b_none", ForwardBE, 32'b00);
        cyc(); RdW = 0; RegWriteM = 0; RegWriteW = 1; Rs1E = 0;
        smp();
        check("fwd_a_x0", ForwardAE, 32'b00);

        // Load-use
        cyc(); clr(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        smp();
        check("load_use", sf(), 32'b110001);
        cyc(); ResultSrcE0 = 0;
        smp();
        check("load_use_bubble", sf(), 32'b000000);
        cyc(); ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
        smp();
        check("load_use_x0", sf(), 32'b000000);

        // Branch overrides load-use
        cyc(); clr(); ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        smp();
        check("branch_kills_lu", sf(), 32'b000011);

        // Memory wait with PCSrcE held
        cyc(); clr(); MemReqM = 1; PCSrcE = 1;
        smp();
        check("mem_wait_c0", sf(), 32'b111100);
        check("mem_wait_c0_state", DbgState, 32'd0);
        cyc(); smp();
        check("mem_wait_c1", sf(), 32'b111100);
        check("mem_wait_c1_state", DbgState, 32'd1);
        cyc(); smp();
        check("mem_wait_c2", sf(), 32'b111100);
        cyc(); MemReadyM = 1;
        smp();
        check("mem_ready_release", sf(), 32'b000011);
        check("mem_ready_noerr", MemErr, 32'd0);
        cyc(); clr();
        smp();
        check("mem_back_run", DbgState, 32'd0);

        // Zero-wait memory
        cyc(); MemReqM = 1; MemReadyM = 1;
        smp();
        check("zero_wait", sf(), 32'b000000);
        cyc(); clr();
        smp();
        check("zero_wait_state", DbgState, 32'd0);

        // Timeout
        cyc(); MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("timeout_hold", {28'd0, StallM, MemErr}, 32'b10);
            cyc();
        end
        smp();
        check("timeout_memerr", MemErr, 32'd1);
        check("timeout_release", sf(), 32'b000000);
        cyc(); clr();
        smp();
        check("timeout_pulse_end", MemErr, 32'd0);
        check("timeout_state", DbgState, 32'd0);
        check("stall_cnt", StallCnt, EXP_STALL);
        check("flush_cnt", FlushCnt, EXP_FLUSH);

        // Async reset mid-wait
        cyc(); MemReqM = 1;
        smp(); cyc();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", DbgState, 32'd0);
        check("async_rst_outputs", sf(), 32'b000011);
        check("async_rst_cnt", StallCnt, 32'd0);
        clr();
        #1 rst_n = 1'b1;
        cyc(); cyc(); smp();
        check("async_rst_after", sf(), 32'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
